// File: rtl/echo_tap_scheduler.sv
// Sequences the shared audio BRAM: per strobe, one optional write then NUM_TAPS delayed reads,
// mixed with the dry sample. Define ECHO_SATURATE_EN to clamp the mix instead of wrapping it.

module echo_tap_scheduler #(
  parameter int unsigned DEPTH        = 18000,
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned NUM_TAPS     = 3,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic [7:0]                 audio_in,
  input  logic                       audio_valid_in,
  input  logic                       record_in,
  input  logic [NUM_TAPS*ADDR_W-1:0] delay_in,
  output logic [ADDR_W-1:0]          wr_addr_out,
  output logic [7:0]                 wr_data_out,
  output logic                       wr_en_out,
  output logic [ADDR_W-1:0]          rd_addr_out,
  input  logic [7:0]                 rd_data_in,
  output logic [7:0]                 mix_out,
  output logic                       mix_valid_out,
  output logic                       busy_out,
  output logic                       overrun_out,
  output logic [ADDR_W-1:0]          fill_count_out
);

  localparam int unsigned TapW = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam int unsigned AccW = 8 + $clog2(NUM_TAPS + 1) + 1;
  localparam logic [ADDR_W:0]        DepthX   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0]      LastAddr = ADDR_W'(DEPTH - 1);
  localparam logic [TapW-1:0]        LastTap  = TapW'(NUM_TAPS - 1);
  localparam logic signed [AccW-1:0] AccMax   = AccW'(127);
  localparam logic signed [AccW-1:0] AccMin   = AccW'(-128);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StOut} state_e;

  state_e                     state_q, state_d;
  logic [TapW-1:0]            tap_q, tap_d;
  logic [ADDR_W-1:0]          base_q, base_d;
  logic [7:0]                 sample_q, sample_d;
  logic                       rec_q, rec_d;
  logic [NUM_TAPS*ADDR_W-1:0] delay_q, delay_d;
  logic [ADDR_W-1:0]          fill_lat_q, fill_lat_d;
  logic [ADDR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]          fill_q, fill_d;
  logic signed [AccW-1:0]     acc_q, acc_d;
  logic                       overrun_q, overrun_d;
  logic [READ_LATENCY-1:0]    pipe_vld_q, pipe_vld_d;
  logic [READ_LATENCY-1:0]    pipe_msk_q, pipe_msk_d;
  logic [TapW-1:0]            pipe_tap_q [READ_LATENCY];
  logic [TapW-1:0]            pipe_tap_d [READ_LATENCY];

  logic                   accept, issuing, last_issue, do_write;
  logic                   cap_vld, cap_msk, last_cap;
  logic [TapW-1:0]        cap_tap;
  logic [ADDR_W-1:0]      cur_delay, tap_addr;
  logic [ADDR_W:0]        tap_addr_x;
  logic                   cur_mask;
  logic signed [7:0]      rd_s, shifted;
  logic signed [AccW-1:0] tap_term;
  logic [7:0]             mix_conv;

  // Strobes are also accepted in the output cycle so samples can run back to back.
  assign accept     = audio_valid_in && (state_q == StIdle || state_q == StOut);
  assign issuing    = (state_q == StIssue);
  assign last_issue = issuing && (tap_q == LastTap);
  assign do_write   = issuing && (tap_q == '0) && rec_q;
  assign cap_vld    = pipe_vld_q[READ_LATENCY-1];
  assign cap_msk    = pipe_msk_q[READ_LATENCY-1];
  assign cap_tap    = pipe_tap_q[READ_LATENCY-1];
  assign last_cap   = cap_vld && (cap_tap == LastTap);

  always_comb begin
    cur_delay = delay_q[int'(tap_q)*ADDR_W +: ADDR_W];
    cur_mask  = (cur_delay == '0) || ({1'b0, cur_delay} >= DepthX) || (cur_delay > fill_lat_q);
    if (base_q >= cur_delay) begin
      tap_addr_x = {1'b0, base_q} - {1'b0, cur_delay};
    end else begin
      tap_addr_x = {1'b0, base_q} + DepthX - {1'b0, cur_delay};
    end
    tap_addr = tap_addr_x[ADDR_W-1:0];
    rd_s     = $signed(rd_data_in);
    shifted  = rd_s >>> (int'(cap_tap) + 1);
    tap_term = {{(AccW-8){shifted[7]}}, shifted};
  end

  always_comb begin
`ifdef ECHO_SATURATE_EN
    if (acc_q > AccMax) begin
      mix_conv = 8'h7f;
    end else if (acc_q < AccMin) begin
      mix_conv = 8'h80;
    end else begin
      mix_conv = acc_q[7:0];
    end
`else
    mix_conv = acc_q[7:0];
`endif
  end

  // State register and datapath flops
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= StIdle;
      tap_q      <= '0;
      base_q     <= '0;
      sample_q   <= '0;
      rec_q      <= 1'b0;
      delay_q    <= '0;
      fill_lat_q <= '0;
      wr_ptr_q   <= '0;
      fill_q     <= '0;
      acc_q      <= '0;
      overrun_q  <= 1'b0;
      pipe_vld_q <= '0;
      pipe_msk_q <= '0;
      pipe_tap_q <= '{default: '0};
    end else begin
      state_q    <= state_d;
      tap_q      <= tap_d;
      base_q     <= base_d;
      sample_q   <= sample_d;
      rec_q      <= rec_d;
      delay_q    <= delay_d;
      fill_lat_q <= fill_lat_d;
      wr_ptr_q   <= wr_ptr_d;
      fill_q     <= fill_d;
      acc_q      <= acc_d;
      overrun_q  <= overrun_d;
      pipe_vld_q <= pipe_vld_d;
      pipe_msk_q <= pipe_msk_d;
      pipe_tap_q <= pipe_tap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (audio_valid_in) state_d = StIssue;
      StIssue: if (last_issue) state_d = StDrain;
      StDrain: if (last_cap) state_d = StOut;
      StOut:   state_d = audio_valid_in ? StIssue : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    tap_d      = tap_q;
    base_d     = base_q;
    sample_d   = sample_q;
    rec_d      = rec_q;
    delay_d    = delay_q;
    fill_lat_d = fill_lat_q;
    wr_ptr_d   = wr_ptr_q;
    fill_d     = fill_q;
    acc_d      = acc_q;
    overrun_d  = overrun_q | (audio_valid_in && (state_q == StIssue || state_q == StDrain));

    if (accept) begin
      tap_d      = '0;
      base_d     = wr_ptr_q;
      sample_d   = audio_in;
      rec_d      = record_in;
      delay_d    = delay_in;
      fill_lat_d = fill_q;
      acc_d      = {{(AccW-8){audio_in[7]}}, audio_in};
    end else if (cap_vld && !cap_msk) begin
      acc_d = acc_q + tap_term;
    end

    if (issuing) begin
      tap_d = last_issue ? '0 : tap_q + 1'b1;
    end

    if (do_write) begin
      wr_ptr_d = (wr_ptr_q == LastAddr) ? '0 : wr_ptr_q + 1'b1;
      if ({1'b0, fill_q} < DepthX) begin
        fill_d = fill_q + 1'b1;
      end
    end

    // Slot k holds the read issued k+1 cycles ago; the last slot lines up with rd_data_in.
    pipe_vld_d[0] = issuing;
    pipe_msk_d[0] = cur_mask;
    pipe_tap_d[0] = tap_q;
    for (int k = 1; k < READ_LATENCY; k++) begin
      pipe_vld_d[k] = pipe_vld_q[k-1];
      pipe_msk_d[k] = pipe_msk_q[k-1];
      pipe_tap_d[k] = pipe_tap_q[k-1];
    end
  end

  always_comb begin
    wr_en_out     = do_write;
    wr_addr_out   = do_write ? base_q : '0;
    wr_data_out   = do_write ? sample_q : '0;
    rd_addr_out   = issuing ? tap_addr : '0;
    mix_valid_out = (state_q == StOut);
    mix_out       = (state_q == StOut) ? mix_conv : '0;
    busy_out      = (state_q == StIssue) || (state_q == StDrain) ||
                    ((state_q == StIdle) && audio_valid_in);
  end

  assign overrun_out    = overrun_q;
  assign fill_count_out = fill_q;

endmodule
